saph_ch_unlerp: RTL
===================

# saph_ch_unlerp

Color channel inverse interpolator: given endpoints `from`/`to` and an observed channel value, computes the 8-bit blend coefficient that `saph_ch_interp`-style lerping maps back onto that value. Used by the blend/gradient setup path to derive per-channel coefficients from sampled colours. It is a multi-cycle restoring divider behind valid/ready handshakes, one request in flight at a time.

## Interface
- No parameters; all datapaths fixed at 8-bit channel width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `in_from`  in  8  start endpoint, unsigned.
- `in_to`  in  8  end endpoint, unsigned.
- `in_value`  in  8  channel value to invert, unsigned.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_coeff`  out  8  computed coefficient.
- `out_sat`  out  1  result was clamped or degenerate; see Operation.

## Operation
- Accept on `in_valid && in_ready`. Inputs are captured that edge and need not be held afterwards.
- Signed 9-bit differences: num = value − from, den = to − from.
- Result rules, evaluated in this order:
  - den == 0: coeff 0, sat 1.
  - num == 0: coeff 0, sat 0.
  - sign(num) ≠ sign(den): coeff 0, sat 1.
  - |num| ≥ |den|: coeff 255, sat 1.
  - Otherwise: coeff = floor(|num|·256 / |den|), which always fits in 0..254, and sat 0.
- The special cases are resolved at acceptance. They skip the divide.
- Divide is restoring, MSB first, using a 9-bit remainder r, initialised to |num|. Each step:
  - r ← r<<1.
  - If r ≥ |den|: r ← r − |den| and the quotient bit is 1; else the bit is 0.
  - 8 steps, tracked by a 3-bit step counter.
- States:
  - IDLE: `in_ready`=1. On accept, go to DONE for a special case, else to CALC.
  - CALC: one quotient bit per cycle. After the 8th step, go to DONE.
  - DONE: `out_valid`=1, with `out_coeff`/`out_sat` stable. On `out_ready`, go to IDLE.
- `in_ready` = (state == IDLE). Requests are never accepted in CALC or DONE.
- `out_coeff`/`out_sat` only change on the transition into DONE. Their value outside DONE is the last result and carries no meaning.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_coeff`=0, `out_sat`=0. The step counter and remainder are cleared.
- Special-case latency: accepted at edge E0, `out_valid`=1 after E0.
- Divide latency: accepted at E0, CALC during cycles E0..E8, `out_valid`=1 after E8 (8 cycles later).
- Throughput: at least one IDLE cycle between the output handshake and the next accept, so a divide costs at most one result per 10 cycles.
- Back-pressure: DONE is held indefinitely while `out_ready`=0. Outputs are held bit-stable.
- `out_ready` has no effect outside DONE.
- `in_valid` outside IDLE is ignored, and the request is not latched.
- Reset asserted in any state, including mid-CALC, takes effect immediately. It discards the in-flight request; no result is emitted.
- No combinational path from any input to any output except through state (`in_ready` and `out_valid` are registered-state decodes).

## Test plan
- from=0, to=255, value=128 -> `out_valid` 8 cycles after accept; coeff 128, sat 0. Separately, from=16, to=32, value=24 -> coeff 128, sat 0.
- Descending ramp: from=200, to=100, value=150 -> coeff 128, sat 0. Separately, from=200, to=100, value=175 -> coeff 64, sat 0.
- Special cases, each with `out_valid` 1 cycle after accept:
  - from=to=50, value=50 -> coeff 0, sat 1.
  - from=10, to=20, value=20 -> coeff 255, sat 1.
  - from=100, to=200, value=50 -> coeff 0, sat 1.
  - from=value=77, to=99 -> coeff 0, sat 0.
- Back-pressure, using from=0, to=3, value=1 (expected coeff 85):
  - Hold `out_ready`=0 for 5 cycles in DONE -> `out_valid` stays 1 with coeff 85 stable, and `in_ready` stays 0.
  - A request driven meanwhile is dropped.
  - After the handshake, `in_ready`=1 on the next cycle.
- Reset mid-CALC: assert `rst` 4 cycles after accepting from=0, to=255, value=200 -> `out_valid` 0 and `in_ready` 1 immediately. A subsequent request from=0, to=255, value=1 yields coeff 1.
- Random sweep, 10k requests: for every non-sat result, check coeff·|den| ≤ |num|·256 < (coeff+1)·|den|.

Source files
------------

// File: rtl/saph_ch_unlerp.sv
// saph_ch_unlerp: colour channel inverse interpolator.
// Given endpoints from/to and an observed value, produces the 8-bit blend
// coefficient c such that lerp(from, to, c/256) lands on value. Degenerate
// and out-of-range requests are resolved at acceptance; the general case
// runs an 8-step restoring divide, one quotient bit per cycle.
//
// Handshake: a request transfers on the rising edge where in_valid and
// in_ready are both 1; a result transfers on the edge where out_valid and
// out_ready are both 1. in_ready and out_valid are pure decodes of the
// registered state, so neither depends combinationally on any input.
// Once out_valid rises, out_coeff/out_sat hold until the result transfers.
module saph_ch_unlerp (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_from,
  input  logic [7:0] in_to,
  input  logic [7:0] in_value,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_coeff,
  output logic       out_sat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;

  logic [8:0] rem;
  logic [7:0] den_mag;
  logic [7:0] quot;
  logic [2:0] step;

  // Request decode: magnitudes and signs of num = value-from, den = to-from.
  logic       num_neg;
  logic       den_neg;
  logic [7:0] num_abs;
  logic [7:0] den_abs;
  logic       special;
  logic [7:0] spec_coeff;
  logic       spec_sat;

  // Single divide step on the current remainder.
  logic [8:0] rem_sh;
  logic       q_bit;
  logic [8:0] rem_nx;
  logic [7:0] quot_nx;

  // Operand magnitudes and the early-out special-case result.
  always_comb begin
    num_neg = (in_value < in_from);
    den_neg = (in_to < in_from);
    num_abs = num_neg ? (in_from - in_value) : (in_value - in_from);
    den_abs = den_neg ? (in_from - in_to) : (in_to - in_from);
    special    = 1'b1;
    spec_coeff = 8'd0;
    spec_sat   = 1'b0;
    if (den_abs == 8'd0) begin
      spec_sat = 1'b1;
    end else if (num_abs == 8'd0) begin
      spec_sat = 1'b0;
    end else if (num_neg != den_neg) begin
      spec_sat = 1'b1;
    end else if (num_abs >= den_abs) begin
      spec_coeff = 8'd255;
      spec_sat   = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

  // Restoring step: shift, trial-subtract, keep the difference if it fits.
  // rem < den_mag <= 255 on entry, so the shifted value fits in 9 bits.
  always_comb begin
    rem_sh  = {rem[7:0], 1'b0};
    q_bit   = (rem_sh >= {1'b0, den_mag});
    rem_nx  = q_bit ? (rem_sh - {1'b0, den_mag}) : rem_sh;
    quot_nx = {quot[6:0], q_bit};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nx = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (step == 3'd7) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, iterate in CALC, latch the result
  // only on the way into DONE so it stays stable under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem       <= 9'd0;
      den_mag   <= 8'd0;
      quot      <= 8'd0;
      step      <= 3'd0;
      out_coeff <= 8'd0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (special) begin
              out_coeff <= spec_coeff;
              out_sat   <= spec_sat;
            end else begin
              rem     <= {1'b0, num_abs};
              den_mag <= den_abs;
              quot    <= 8'd0;
              step    <= 3'd0;
            end
          end
        end
        CALC: begin
          rem  <= rem_nx;
          quot <= quot_nx;
          step <= step + 3'd1;
          if (step == 3'd7) begin
            out_coeff <= quot_nx;
            out_sat   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake flags are decodes of the registered state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

endmodule
